// File: rtl/snn_frame_loader.sv
// -----------------------------------------------------------------------------
// snn_frame_loader
//
// Receive / classify / transmit controller for the SNN core.
//   * Collects a frame of UART bytes and unpacks each byte, LSB-first, into
//     PIX_W-bit pixels that are written one per cycle into the input RAM.
//   * When the last pixel (NPIX-1) has been written, launches the core with a
//     single-cycle pulse, waits for it to finish, captures the digit and sends
//     one result byte {RES_HI, digit} over the UART transmitter.
//   * A one-byte skid register absorbs a byte that arrives while the previous
//     byte is still being unpacked; any further byte is dropped (overrun).
//   * A partial frame that stalls for TIMEOUT_CYC idle cycles is abandoned
//     (frame_err) and the next byte starts a new frame at address 0.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   rx_rdy_i       one-cycle pulse, rx_data_i valid
//   rx_data_i      received byte
//   ram_we_o       RAM write enable (only in UNPACK)
//   ram_addr_o     RAM write address (pixel index)
//   ram_wdata_o    pixel value
//   core_start_o   one-cycle core launch pulse
//   core_done_i    core finished (pulse or level, sampled in CORE only)
//   core_digit_i   classification result
//   tx_start_o     one-cycle transmit request
//   tx_data_o      byte to transmit
//   tx_rdy_i       transmitter idle
//   result_o       last transmitted byte, held
//   busy_o         high in every state except RX_WAIT
//   frame_err_o    sticky: a partial frame was aborted by the timeout
//   overrun_o      sticky: a received byte was dropped
//   clr_err_i      clears both sticky flags (a simultaneous set wins)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module snn_frame_loader #(
  parameter int unsigned NPIX        = 784,
  parameter int unsigned PIX_W       = 1,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 2500000,
  parameter logic [3:0]  RES_HI      = 4'h3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy_i,
  input  logic [7:0]        rx_data_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [PIX_W-1:0]  ram_wdata_o,
  output logic              core_start_o,
  input  logic              core_done_i,
  input  logic [3:0]        core_digit_i,
  output logic              tx_start_o,
  output logic [7:0]        tx_data_o,
  input  logic              tx_rdy_i,
  output logic [7:0]        result_o,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overrun_o,
  input  logic              clr_err_i
);

  // Pixels carried by one received byte.
  localparam int unsigned PPB = 8 / PIX_W;

  localparam logic [2:0]        SUB_LAST = 3'(PPB - 1);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);

  // Timeout counter only needs to reach TIMEOUT_CYC-1.
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {
    S_RX_WAIT  = 3'd0,
    S_UNPACK   = 3'd1,
    S_START    = 3'd2,
    S_CORE     = 3'd3,
    S_TX_REQ   = 3'd4,
    S_TX_DRAIN = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pix_q,   pix_d;    // next pixel address
  logic [2:0]        sub_q,   sub_d;    // pixel index within current byte
  logic [7:0]        dat_q,   dat_d;    // byte being unpacked (shifted right)
  logic              pend_q,  pend_d;   // skid register holds a byte
  logic [7:0]        pbuf_q,  pbuf_d;   // skid register
  logic [TMO_W-1:0]  tmo_q,   tmo_d;    // idle cycles inside a partial frame
  logic [7:0]        txd_q,   txd_d;
  logic [7:0]        res_q,   res_d;
  logic              seen_q,  seen_d;   // tx_rdy observed low in TX_DRAIN
  logic              ferr_q,  ferr_d;
  logic              ovr_q,   ovr_d;

  logic              ferr_set;
  logic              ovr_set;
  logic              we;
  logic              cstart;
  logic              tstart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RX_WAIT;
      pix_q   <= '0;
      sub_q   <= '0;
      dat_q   <= '0;
      pend_q  <= 1'b0;
      pbuf_q  <= '0;
      tmo_q   <= '0;
      txd_q   <= '0;
      res_q   <= '0;
      seen_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      sub_q   <= sub_d;
      dat_q   <= dat_d;
      pend_q  <= pend_d;
      pbuf_q  <= pbuf_d;
      tmo_q   <= tmo_d;
      txd_q   <= txd_d;
      res_q   <= res_d;
      seen_q  <= seen_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    sub_d    = sub_q;
    dat_d    = dat_q;
    pend_d   = pend_q;
    pbuf_d   = pbuf_q;
    tmo_d    = '0;          // counter only survives idle RX_WAIT cycles
    txd_d    = txd_q;
    res_d    = res_q;
    seen_d   = seen_q;
    ferr_set = 1'b0;
    ovr_set  = 1'b0;
    we       = 1'b0;
    cstart   = 1'b0;
    tstart   = 1'b0;

    case (state_q)
      S_RX_WAIT: begin
        sub_d = '0;
        if (pend_q) begin
          // Skid byte is older, so it goes first; a fresh byte in the same
          // cycle refills the skid register.
          dat_d   = pbuf_q;
          pend_d  = 1'b0;
          state_d = S_UNPACK;
          if (rx_rdy_i) begin
            pbuf_d = rx_data_i;
            pend_d = 1'b1;
          end
        end else if (rx_rdy_i) begin
          dat_d   = rx_data_i;
          state_d = S_UNPACK;
        end else if (TMO_EN && (pix_q != '0)) begin
          if (tmo_q == TMO_LAST) begin
            ferr_set = 1'b1;
            pix_d    = '0;
            pend_d   = 1'b0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end

      S_UNPACK: begin
        we    = 1'b1;
        dat_d = dat_q >> PIX_W;
        sub_d = sub_q + 1'b1;
        pix_d = pix_q + 1'b1;
        // Last pixel of the frame wins over end-of-byte: leftover bits of the
        // final byte are simply discarded.
        if (pix_q == PIX_LAST) begin
          state_d = S_START;
        end else if (sub_q == SUB_LAST) begin
          state_d = S_RX_WAIT;
        end
        if (rx_rdy_i) begin
          if (pend_q) begin
            ovr_set = 1'b1;
          end else begin
            pend_d = 1'b1;
            pbuf_d = rx_data_i;
          end
        end
      end

      S_START: begin
        cstart  = 1'b1;
        pix_d   = '0;
        state_d = S_CORE;
        ovr_set = rx_rdy_i;
      end

      S_CORE: begin
        ovr_set = rx_rdy_i;
        if (core_done_i) begin
          txd_d   = {RES_HI, core_digit_i};
          state_d = S_TX_REQ;
        end
      end

      S_TX_REQ: begin
        ovr_set = rx_rdy_i;
        seen_d  = 1'b0;
        if (tx_rdy_i) begin
          tstart  = 1'b1;
          res_d   = txd_q;
          state_d = S_TX_DRAIN;
        end
      end

      S_TX_DRAIN: begin
        // The transmitter needs a cycle or two to drop tx_rdy; only a rising
        // tx_rdy after a low phase marks the byte as sent.
        ovr_set = rx_rdy_i;
        if (!tx_rdy_i) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          seen_d  = 1'b0;
          state_d = S_RX_WAIT;
        end
      end

      default: begin
        state_d = S_RX_WAIT;
      end
    endcase

    // Set has priority over clear.
    ferr_d = ferr_set | (ferr_q & ~clr_err_i);
    ovr_d  = ovr_set  | (ovr_q  & ~clr_err_i);
  end

  assign ram_we_o     = we;
  assign ram_addr_o   = pix_q;
  assign ram_wdata_o  = dat_q[PIX_W-1:0];
  assign core_start_o = cstart;
  assign tx_start_o   = tstart;
  assign tx_data_o    = txd_q;
  assign result_o     = res_q;
  assign busy_o       = (state_q != S_RX_WAIT);
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_snn_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_snn_frame_loader
//
// Two loaders side by side:
//   u_a : default build (784 one-bit pixels, 98-byte frame, long timeout)
//   u_b : 45 four-bit pixels (23 bytes, last high nibble discarded),
//         TIMEOUT_CYC = 100
// A monitor logs every RAM write and every core_start / tx_start pulse; the
// expected pixel stream is computed directly from the bytes that were sent.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_snn_frame_loader;

  localparam int NPIX_A = 784;
  localparam int PW_A   = 1;
  localparam int NPIX_B = 45;
  localparam int PW_B   = 4;
  localparam int TMO_B  = 100;
  localparam int LOGN   = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_rdy     [2];
  logic [7:0] rx_data    [2];
  logic       core_done  [2];
  logic [3:0] core_digit [2];
  logic       tx_rdy     [2];
  logic       clr_err    [2];

  wire        ram_we     [2];
  wire  [9:0] ram_addr   [2];
  wire  [0:0] wdata_a;
  wire  [3:0] wdata_b;
  wire        core_start [2];
  wire        tx_start   [2];
  wire  [7:0] tx_data    [2];
  wire  [7:0] result     [2];
  wire        busy       [2];
  wire        frame_err  [2];
  wire        overrun    [2];

  snn_frame_loader u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_rdy_i     (rx_rdy[0]),
    .rx_data_i    (rx_data[0]),
    .ram_we_o     (ram_we[0]),
    .ram_addr_o   (ram_addr[0]),
    .ram_wdata_o  (wdata_a),
    .core_start_o (core_start[0]),
    .core_done_i  (core_done[0]),
    .core_digit_i (core_digit[0]),
    .tx_start_o   (tx_start[0]),
    .tx_data_o    (tx_data[0]),
    .tx_rdy_i     (tx_rdy[0]),
    .result_o     (result[0]),
    .busy_o       (busy[0]),
    .frame_err_o  (frame_err[0]),
    .overrun_o    (overrun[0]),
    .clr_err_i    (clr_err[0])
  );

  snn_frame_loader #(
    .NPIX        (NPIX_B),
    .PIX_W       (PW_B),
    .ADDR_W      (10),
    .TIMEOUT_CYC (TMO_B),
    .RES_HI      (4'h3)
  ) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_rdy_i     (rx_rdy[1]),
    .rx_data_i    (rx_data[1]),
    .ram_we_o     (ram_we[1]),
    .ram_addr_o   (ram_addr[1]),
    .ram_wdata_o  (wdata_b),
    .core_start_o (core_start[1]),
    .core_done_i  (core_done[1]),
    .core_digit_i (core_digit[1]),
    .tx_start_o   (tx_start[1]),
    .tx_data_o    (tx_data[1]),
    .tx_rdy_i     (tx_rdy[1]),
    .result_o     (result[1]),
    .busy_o       (busy[1]),
    .frame_err_o  (frame_err[1]),
    .overrun_o    (overrun[1]),
    .clr_err_i    (clr_err[1])
  );

  // ---------------------------------------------------------------------------
  // Monitor: append-only logs, read by the stimulus through baselines.
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int wn      [2] = '{0, 0};
  int wa      [2][LOGN];
  int wd      [2][LOGN];
  int last_wr [2] = '{0, 0};
  int cs_cnt  [2] = '{0, 0};
  int cs_cyc  [2] = '{0, 0};
  int ts_cnt  [2] = '{0, 0};
  int ts_data [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (ram_we[i] && wn[i] < LOGN) begin
          wa[i][wn[i]] <= int'(ram_addr[i]);
          wd[i][wn[i]] <= (i == 0) ? int'(wdata_a) : int'(wdata_b);
          wn[i]        <= wn[i] + 1;
          last_wr[i]   <= cyc;
        end
        if (core_start[i]) begin
          cs_cnt[i] <= cs_cnt[i] + 1;
          cs_cyc[i] <= cyc;
        end
        if (tx_start[i]) begin
          ts_cnt[i]  <= ts_cnt[i] + 1;
          ts_data[i] <= int'(tx_data[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb [2][128];   // bytes of the frame currently being sent

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All stimulus runs 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle rx pulse; next pulse can follow iv cycles later.
  task automatic send_byte(input int id, input logic [7:0] b, input int iv);
    rx_rdy[id]  = 1'b1;
    rx_data[id] = b;
    tick();
    rx_rdy[id]  = 1'b0;
    repeat (iv - 1) tick();
  endtask

  // mode 0: random bytes, 1: all 0xA5, 2: random ending in 21 43 65
  task automatic send_frame(input int id, input int nb, input int mode,
                            input int lo, input int hi);
    logic [7:0] b;
    for (int k = 0; k < nb; k++) begin
      b = (mode == 1) ? 8'hA5 : 8'($urandom);
      if (mode == 2 && k == nb - 3) b = 8'h21;
      if (mode == 2 && k == nb - 2) b = 8'h43;
      if (mode == 2 && k == nb - 1) b = 8'h65;
      sb[id][k] = b;
      send_byte(id, b, int'($urandom_range(hi, lo)));
    end
  endtask

  // Expected stream: pixel k = byte[k/PPB] bits [(k%PPB)*PIX_W +: PIX_W],
  // at address k, for k < min(NPIX, bytes*PPB).
  task automatic check_writes(input int id, input int nb, input int base, input string tag);
    int pw, np, ppb, expn, nbad, ed;
    pw   = (id == 0) ? PW_A : PW_B;
    np   = (id == 0) ? NPIX_A : NPIX_B;
    ppb  = 8 / pw;
    expn = nb * ppb;
    if (expn > np) expn = np;
    chk({tag, "_nwr"}, wn[id] - base, expn);
    nbad = 0;
    for (int k = 0; k < expn; k++) begin
      if (base + k < wn[id]) begin
        ed = (int'(sb[id][k / ppb]) >> ((k % ppb) * pw)) & ((1 << pw) - 1);
        if (wa[id][base + k] != k || wd[id][base + k] != ed) nbad++;
      end
    end
    chk({tag, "_pix_bad"}, nbad, 0);
  endtask

  task automatic chk_reset(input int id, input string tag);
    chk({tag, "_ctl"}, {ram_we[id], core_start[id], tx_start[id], busy[id],
                        frame_err[id], overrun[id]}, 0);
    chk({tag, "_addr"}, ram_addr[id], 0);
    chk({tag, "_wdata"}, (id == 0) ? 32'(wdata_a) : 32'(wdata_b), 0);
    chk({tag, "_txdata"}, tx_data[id], 0);
    chk({tag, "_result"}, result[id], 0);
  endtask

  // From the end of the last byte: core launch, digit, UART result byte.
  task automatic finish_frame(input int id, input int cs0, input int ts0,
                              input logic [3:0] dig, input bit ovr_test,
                              input string tag);
    int w0;
    for (int i = 0; i < 60 && cs_cnt[id] == cs0; i++) tick();
    chk({tag, "_cs_seen"}, cs_cnt[id] - cs0, 1);
    chk({tag, "_cs_after_wr"}, cs_cyc[id], last_wr[id] + 1);
    chk({tag, "_busy_core"}, busy[id], 1);
    if (ovr_test) begin
      w0 = wn[id];
      send_byte(id, 8'($urandom), 2);
      chk({tag, "_ovr_core"}, overrun[id], 1);
      clr_err[id] = 1'b1;
      send_byte(id, 8'h5A, 1);
      clr_err[id] = 1'b0;
      chk({tag, "_ovr_set_wins"}, overrun[id], 1);
      clr_err[id] = 1'b1;
      tick();
      clr_err[id] = 1'b0;
      chk({tag, "_ovr_clr"}, overrun[id], 0);
      chk({tag, "_no_wr_core"}, wn[id] - w0, 0);
    end
    core_digit[id] = dig;
    core_done[id]  = 1'b1;
    tick();
    core_done[id]  = 1'b0;
    for (int i = 0; i < 20 && ts_cnt[id] == ts0; i++) tick();
    chk({tag, "_ts_seen"}, ts_cnt[id] - ts0, 1);
    chk({tag, "_ts_data"}, ts_data[id], {24'h0, 4'h3, dig});
    repeat (3) tick();
    chk({tag, "_busy_drain_hi"}, busy[id], 1);
    tx_rdy[id] = 1'b0;
    repeat (4) tick();
    chk({tag, "_busy_drain_lo"}, busy[id], 1);
    tx_rdy[id] = 1'b1;
    repeat (2) tick();
    chk({tag, "_idle"}, busy[id], 0);
    chk({tag, "_result"}, result[id], {4'h3, dig});
    chk({tag, "_txdata"}, tx_data[id], {4'h3, dig});
    chk({tag, "_one_cs"}, cs_cnt[id] - cs0, 1);
    chk({tag, "_one_ts"}, ts_cnt[id] - ts0, 1);
    chk({tag, "_ferr"}, frame_err[id], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int base, cs0, ts0;
    logic [3:0] dig;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rx_rdy[i]     = 1'b0;
      rx_data[i]    = 8'h00;
      core_done[i]  = 1'b0;
      core_digit[i] = 4'h0;
      tx_rdy[i]     = 1'b1;
      clr_err[i]    = 1'b0;
    end
    repeat (3) tick();
    chk_reset(0, "rstA");
    chk_reset(1, "rstB");
    rst_n = 1'b1;
    tick();

    // B1: 23 bytes, last three 21 43 65 -> pixels 40..44 = 1..5, nibble 6 dropped
    base = wn[1]; cs0 = cs_cnt[1]; ts0 = ts_cnt[1];
    send_frame(1, 23, 2, 3, 10);
    dig = 4'($urandom);
    finish_frame(1, cs0, ts0, dig, 1'b0, "B1");
    check_writes(1, 23, base, "B1");
    chk("B1_pix44", wd[1][base + 44], 5);
    chk("B1_ovr", overrun[1], 0);

    // B2: 10 bytes then silence -> frame abort
    base = wn[1];
    send_frame(1, 10, 0, 5, 5);
    repeat (80) tick();
    chk("B2_ferr_early", frame_err[1], 0);
    chk("B2_busy", busy[1], 0);
    repeat (30) tick();
    chk("B2_ferr", frame_err[1], 1);
    check_writes(1, 10, base, "B2");
    clr_err[1] = 1'b1;
    tick();
    clr_err[1] = 1'b0;
    chk("B2_ferr_clr", frame_err[1], 0);

    // B3: next frame restarts at address 0 and completes
    base = wn[1]; cs0 = cs_cnt[1]; ts0 = ts_cnt[1];
    send_frame(1, 23, 0, 3, 10);
    dig = 4'($urandom);
    finish_frame(1, cs0, ts0, dig, 1'b0, "B3");
    check_writes(1, 23, base, "B3");

    // A1: 98 x 0xA5, 20-cycle spacing, digit 7 -> 0x37
    base = wn[0]; cs0 = cs_cnt[0]; ts0 = ts_cnt[0];
    send_frame(0, 98, 1, 20, 20);
    finish_frame(0, cs0, ts0, 4'd7, 1'b0, "A1");
    check_writes(0, 98, base, "A1");
    chk("A1_result37", result[0], 8'h37);

    // A2: random frame, bytes during CORE are dropped
    base = wn[0]; cs0 = cs_cnt[0]; ts0 = ts_cnt[0];
    send_frame(0, 98, 0, 9, 20);
    dig = 4'($urandom);
    finish_frame(0, cs0, ts0, dig, 1'b1, "A2");
    check_writes(0, 98, base, "A2");

    // A3: skid register takes one byte, a third one overruns
    base = wn[0];
    sb[0][0] = 8'($urandom);
    sb[0][1] = 8'($urandom);
    send_byte(0, sb[0][0], 2);
    send_byte(0, sb[0][1], 2);
    chk("A3_ovr_none", overrun[0], 0);
    send_byte(0, 8'($urandom), 20);
    chk("A3_ovr", overrun[0], 1);
    check_writes(0, 2, base, "A3");

    // A4: reset while writing address 300
    for (int k = 0; k < 35; k++) send_byte(0, 8'($urandom), 12);
    send_byte(0, 8'($urandom), 1);
    repeat (4) tick();
    chk("A4_we", ram_we[0], 1);
    chk("A4_addr300", ram_addr[0], 300);
    rst_n = 1'b0;
    #1;
    chk_reset(0, "A4rst");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // A5: fresh frame after reset starts at address 0
    base = wn[0]; cs0 = cs_cnt[0]; ts0 = ts_cnt[0];
    send_frame(0, 98, 0, 9, 20);
    dig = 4'($urandom);
    finish_frame(0, cs0, ts0, dig, 1'b0, "A5");
    check_writes(0, 98, base, "A5");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
